// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode instruction FIFO carrying {instr, pc}; presents a NOP when empty, flushes on redirect.
// Optional FETCH_QUEUE_BYPASS_EN: an empty queue forwards the fetch word straight to decode.
module instr_fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int BIT_COUNT = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Flush,
  input  logic                       FetchValid,
  output logic                       FetchReady,
  input  logic [31:0]                FetchInstr,
  input  logic [BIT_COUNT-1:0]       FetchPC,
  output logic                       DecodeValid,
  input  logic                       DecodeReady,
  output logic [31:0]                DecodeInstr,
  output logic [BIT_COUNT-1:0]       DecodePC,
  output logic [BIT_COUNT-1:0]       DecodePCPlus4,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]   NOP        = 32'h00000013;

  logic [31:0]          instr_mem [DEPTH];
  logic [BIT_COUNT-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic                 empty, push, pop, wr_en, rd_en, bypass;

  assign empty      = (count == '0);
  assign FetchReady = (count < FULL_COUNT);
  assign push       = FetchValid & FetchReady;
  assign pop        = DecodeValid & DecodeReady;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & FetchValid & ~Flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode accepts this cycle never enters storage.
  assign wr_en = push & ~Flush & ~(bypass & DecodeReady);
  assign rd_en = pop & ~bypass;

  always_comb begin
    DecodeValid = ~empty & ~Flush;
    DecodeInstr = NOP;
    DecodePC    = '0;
    if (bypass) begin
      DecodeValid = 1'b1;
      DecodeInstr = FetchInstr;
      DecodePC    = FetchPC;
    end else if (DecodeValid) begin
      DecodeInstr = instr_mem[rd_ptr];
      DecodePC    = pc_mem[rd_ptr];
    end
  end

  assign DecodePCPlus4 = DecodePC + BIT_COUNT'(4);
  assign Count         = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !rd_en)      count <= count + CW'(1);
      else if (rd_en && !wr_en) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem[wr_ptr] <= FetchInstr;
      pc_mem[wr_ptr]    <= FetchPC;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: scoreboard model checked every cycle plus directed scenarios.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int BW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset, Flush, FetchValid, DecodeReady;
  logic [31:0]   FetchInstr;
  logic [BW-1:0] FetchPC;
  logic          FetchReady, DecodeValid;
  logic [31:0]   DecodeInstr;
  logic [BW-1:0] DecodePC, DecodePCPlus4;
  logic [CW-1:0] Count;

  int checks   = 0;
  int failures = 0;
  logic [31+BW:0] sbq[$];

  instr_fetch_queue #(.DEPTH(DEPTH), .BIT_COUNT(BW)) dut (
    .clk(clk), .reset(reset), .Flush(Flush),
    .FetchValid(FetchValid), .FetchReady(FetchReady),
    .FetchInstr(FetchInstr), .FetchPC(FetchPC),
    .DecodeValid(DecodeValid), .DecodeReady(DecodeReady),
    .DecodeInstr(DecodeInstr), .DecodePC(DecodePC),
    .DecodePCPlus4(DecodePCPlus4), .Count(Count)
  );

  always #5 clk = ~clk;

  // Scoreboard: expected outputs from the model, then model update for the coming edge.
  always @(negedge clk) begin
    int n;
    logic ev, byp, pop_m, push_m;
    logic [31:0] ei;
    logic [BW-1:0] ep, ep4;
    if (reset) begin
      sbq.delete();
    end else begin
      n   = sbq.size();
      byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = (n == 0) && FetchValid && !Flush;
`endif
      ev = ((n != 0) || byp) && !Flush;
      ei = 32'h00000013;
      ep = '0;
      if (ev && n != 0) begin
        ei = sbq[0][31+BW:BW];
        ep = sbq[0][BW-1:0];
      end else if (ev) begin
        ei = FetchInstr;
        ep = FetchPC;
      end
      ep4 = ep + BW'(4);
      checks += 6;
      if (DecodeValid !== ev) begin failures++; $display("FAIL sb_valid got=%b exp=%b t=%0t", DecodeValid, ev, $time); end
      if (DecodeInstr !== ei) begin failures++; $display("FAIL sb_instr got=%h exp=%h t=%0t", DecodeInstr, ei, $time); end
      if (DecodePC !== ep) begin failures++; $display("FAIL sb_pc got=%h exp=%h t=%0t", DecodePC, ep, $time); end
      if (DecodePCPlus4 !== ep4) begin failures++; $display("FAIL sb_pc4 got=%h exp=%h t=%0t", DecodePCPlus4, ep4, $time); end
      if (Count !== CW'(n)) begin failures++; $display("FAIL sb_count got=%0d exp=%0d t=%0t", Count, n, $time); end
      if (FetchReady !== (n < DEPTH)) begin failures++; $display("FAIL sb_ready got=%b exp=%b t=%0t", FetchReady, (n < DEPTH), $time); end
      if (Flush) begin
        sbq.delete();
      end else begin
        pop_m  = ev && DecodeReady;
        push_m = FetchValid && (n < DEPTH);
        if (pop_m && n != 0) void'(sbq.pop_front());
        if (push_m && !(pop_m && n == 0)) sbq.push_back({FetchInstr, FetchPC});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Flush = 0; FetchValid = 0; DecodeReady = 0;
    FetchInstr = 32'hDEADBEEF; FetchPC = BW'(32'hBAD0);
  endtask

  task automatic drain();
    DecodeReady = 1; FetchValid = 0;
    for (int i = 0; i < DEPTH + 2; i++) cyc();
    DecodeReady = 0;
    checks++;
    if (Count !== '0 || sbq.size() != 0) begin
      failures++; $display("FAIL drain count=%0d model=%0d exp=0", Count, sbq.size());
    end
  endtask

  task automatic test_reset();
    reset = 1; idle();
    FetchValid = 1; FetchInstr = 32'h11111111; FetchPC = BW'(32'h40);
    cyc(); cyc();
    checks += 5;
    if (DecodeValid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", DecodeValid); end
    if (DecodeInstr !== 32'h00000013) begin failures++; $display("FAIL rst_instr got=%h exp=00000013", DecodeInstr); end
    if (DecodePC !== '0) begin failures++; $display("FAIL rst_pc got=%h exp=0", DecodePC); end
    if (DecodePCPlus4 !== BW'(4)) begin failures++; $display("FAIL rst_pc4 got=%h exp=4", DecodePCPlus4); end
    if (Count !== '0) begin failures++; $display("FAIL rst_count got=%0d exp=0", Count); end
    reset = 0; FetchValid = 0;
    cyc();
    checks += 2;
    if (FetchReady !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", FetchReady); end
    if (DecodeValid !== 1'b0) begin failures++; $display("FAIL rst_nowrite got=%b exp=0", DecodeValid); end
  endtask

  task automatic test_single();
    FetchValid = 1; FetchInstr = 32'h00500093; FetchPC = BW'(32'h100);
    cyc();
    FetchValid = 0; DecodeReady = 1;
    checks += 4;
    if (DecodeValid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", DecodeValid); end
    if (DecodeInstr !== 32'h00500093) begin failures++; $display("FAIL single_instr got=%h exp=00500093", DecodeInstr); end
    if (DecodePC !== BW'(32'h100)) begin failures++; $display("FAIL single_pc got=%h exp=100", DecodePC); end
    if (DecodePCPlus4 !== BW'(32'h104)) begin failures++; $display("FAIL single_pc4 got=%h exp=104", DecodePCPlus4); end
    cyc();
    DecodeReady = 0;
    checks++;
    if (Count !== '0) begin failures++; $display("FAIL single_count got=%0d exp=0", Count); end
  endtask

  task automatic test_fill_drain();
    DecodeReady = 0;
    for (int i = 0; i < 5; i++) begin
      FetchValid = 1; FetchInstr = 32'hA000_0000 + 32'(i); FetchPC = BW'(i * 4);
      checks++;
      if (FetchReady !== (i < DEPTH)) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=%b", i, FetchReady, (i < DEPTH)); end
      cyc();
    end
    FetchValid = 0;
    checks += 3;
    if (Count !== CW'(DEPTH)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", Count, DEPTH); end
    if (FetchReady !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", FetchReady); end
    if (DecodePC !== '0) begin failures++; $display("FAIL full_head got=%h exp=0", DecodePC); end
    // Full with simultaneous push and pop: only the pop happens.
    FetchValid = 1; FetchInstr = 32'hBBBB0000; FetchPC = BW'(32'h77); DecodeReady = 1;
    cyc();
    FetchValid = 0;
    checks += 2;
    if (Count !== CW'(DEPTH - 1)) begin failures++; $display("FAIL fullpp_count got=%0d exp=%0d", Count, DEPTH - 1); end
    if (FetchReady !== 1'b1) begin failures++; $display("FAIL drain_ready got=%b exp=1", FetchReady); end
    drain();
  endtask

  task automatic test_flush();
    DecodeReady = 0; FetchValid = 1;
    for (int i = 0; i < 2; i++) begin
      FetchInstr = 32'hC000_0000 + 32'(i); FetchPC = BW'(32'h180 + i * 4);
      cyc();
    end
    Flush = 1; FetchInstr = 32'hCCCCCCCC; FetchPC = BW'(32'h200); DecodeReady = 1;
    #1;
    checks++;
    if (DecodeValid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", DecodeValid); end
    cyc();
    Flush = 0; FetchValid = 0;
    checks += 3;
    if (Count !== '0) begin failures++; $display("FAIL flush_count got=%0d exp=0", Count); end
    if (DecodeInstr !== 32'h00000013) begin failures++; $display("FAIL flush_instr got=%h exp=00000013", DecodeInstr); end
    if (DecodeValid !== 1'b0) begin failures++; $display("FAIL flush_absent got=%b exp=0", DecodeValid); end
    DecodeReady = 0;
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] exp_pc;
    DecodeReady = 0; FetchValid = 1;
    FetchInstr = 32'hD0000000; FetchPC = BW'(32'h1000);
    cyc();
    DecodeReady = 1;
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      FetchInstr = 32'hD0000000 + 32'(i); FetchPC = BW'(32'h1000 + i * 4);
      cyc();
      exp_pc = BW'(32'h1000 + i * 4);
      checks += 2;
      if (Count !== CW'(1)) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=1", i, Count); end
      if (DecodePC !== exp_pc) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, DecodePC, exp_pc); end
    end
    drain();
  endtask

  task automatic test_pc_wrap();
    DecodeReady = 0; FetchValid = 1;
    FetchInstr = 32'hE0000000; FetchPC = BW'(32'hFFFFFFFC);
    cyc();
    FetchValid = 0;
    checks++;
    if (DecodePCPlus4 !== '0) begin failures++; $display("FAIL pc_wrap got=%h exp=0", DecodePCPlus4); end
    drain();
  endtask

  task automatic test_reset_mid();
    DecodeReady = 0; FetchValid = 1;
    for (int i = 0; i < 3; i++) begin
      FetchInstr = 32'hF000_0000 + 32'(i); FetchPC = BW'(32'h2000 + i * 4);
      cyc();
    end
    FetchValid = 0;
    #2 reset = 1;
    #1;
    checks += 2;
    if (Count !== '0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", Count); end
    if (DecodeValid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", DecodeValid); end
    cyc();
    reset = 0;
    cyc();
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    DecodeReady = 1; FetchValid = 1;
    FetchInstr = 32'h12345678; FetchPC = BW'(32'h300);
    #1;
    checks += 2;
    if (DecodeValid !== 1'b1) begin failures++; $display("FAIL byp_valid got=%b exp=1", DecodeValid); end
    if (DecodePC !== BW'(32'h300)) begin failures++; $display("FAIL byp_pc got=%h exp=300", DecodePC); end
    cyc();
    FetchValid = 0;
    checks++;
    if (Count !== '0) begin failures++; $display("FAIL byp_count got=%0d exp=0", Count); end
    DecodeReady = 0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; idle();
    test_reset();
    test_single();
    test_fill_drain();
    test_flush();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
